// File: rtl/down_counter_pkg.sv
// Shared counter defaults and build-option defaults for the down counter.
// Build option: DOWN_COUNTER_RELOAD_EN selects auto-reload on underflow.
`ifndef COUNTER_DEFS_VH
`define COUNTER_DEFS_VH
`endif

package down_counter_pkg;

    localparam int DEFAULT_COUNTER_WIDTH = 3;
    localparam int DEFAULT_RESET_VAL     = 0;

`ifdef DOWN_COUNTER_RELOAD_EN
    localparam bit RELOAD_BUILD = 1'b1;
`else
    localparam bit RELOAD_BUILD = 1'b0;
`endif

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_LOAD = 2'd1,
        OP_DEC  = 2'd2,
        OP_WRAP = 2'd3
    } cnt_op_e;

endpackage

// File: rtl/down_counter.sv
// Presettable synchronous down counter with cascadable borrow and sticky underflow.
// Build option: DOWN_COUNTER_RELOAD_EN wraps to the last loaded value instead of all-ones.
module down_counter
    import down_counter_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_COUNTER_WIDTH,
    parameter int RESET_VAL = DEFAULT_RESET_VAL
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    output logic             BO,
    output logic             ZERO,
    output logic             UF,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] RST_COUNT = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_VAL   = WIDTH'(32'd1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             uf_q;
    logic             uf_d;
    logic [WIDTH-1:0] wrap_val_s;
    logic             zero_s;
    cnt_op_e          op_s;

    assign zero_s = (count_q == {WIDTH{1'b0}});

    // Operation select: LOAD outranks CE; RST is applied in the register stage.
    always_comb begin
        op_s = OP_HOLD;
        if (LOAD) begin
            op_s = OP_LOAD;
        end else if (CE) begin
            if (zero_s) begin
                op_s = OP_WRAP;
            end else begin
                op_s = OP_DEC;
            end
        end else begin
            op_s = OP_HOLD;
        end
    end

`ifdef DOWN_COUNTER_RELOAD_EN
    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] reload_d;

    // Reload register captures every parallel load.
    always_comb begin
        reload_d = reload_q;
        if (op_s == OP_LOAD) begin
            reload_d = D;
        end else begin
            reload_d = reload_q;
        end
    end

    // Reload register state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            reload_q <= RST_COUNT;
        end else begin
            reload_q <= reload_d;
        end
    end

    assign wrap_val_s = reload_q;
`else
    assign wrap_val_s = ALL_ONES;
`endif

    // Next count and underflow flag; UF is sticky until the next load or reset.
    always_comb begin
        count_d = count_q;
        uf_d    = uf_q;
        case (op_s)
            OP_LOAD: begin
                count_d = D;
                uf_d    = 1'b0;
            end
            OP_DEC: begin
                count_d = count_q - ONE_VAL;
                uf_d    = uf_q;
            end
            OP_WRAP: begin
                count_d = wrap_val_s;
                uf_d    = 1'b1;
            end
            default: begin
                count_d = count_q;
                uf_d    = uf_q;
            end
        endcase
    end

    // Counter and flag state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            count_q <= RST_COUNT;
            uf_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            uf_q    <= uf_d;
        end
    end

    // Borrow is gated by CE so it can drive the next stage's enable directly.
    assign BO    = CE & zero_s;
    assign ZERO  = zero_s;
    assign UF    = uf_q;
    assign count = count_q;

endmodule

// File: tb/tb_down_counter.sv
// Self-checking bench for down_counter: vector table, cascade pair and reload sequence.
module tb_down_counter;

`ifdef DOWN_COUNTER_RELOAD_EN
    localparam bit R = 1'b1;
`else
    localparam bit R = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b0, ce = 1'b0, load = 1'b0;
    logic [2:0] d = 3'd0;
    logic       bo, zero, uf;
    logic [2:0] cnt;

    logic       c_rst = 1'b1, c_ce = 1'b0, c_load = 1'b0;
    logic [2:0] lo_d = 3'd0, hi_d = 3'd0;
    logic       lo_bo, lo_zero, lo_uf, hi_bo, hi_zero, hi_uf;
    logic [2:0] lo_cnt, hi_cnt;

    down_counter #(.WIDTH(3), .RESET_VAL(5)) dut (
        .CLK(clk), .RST(rst), .CE(ce), .LOAD(load), .D(d),
        .BO(bo), .ZERO(zero), .UF(uf), .count(cnt)
    );

    down_counter #(.WIDTH(3), .RESET_VAL(0)) u_lo (
        .CLK(clk), .RST(c_rst), .CE(c_ce), .LOAD(c_load), .D(lo_d),
        .BO(lo_bo), .ZERO(lo_zero), .UF(lo_uf), .count(lo_cnt)
    );

    down_counter #(.WIDTH(3), .RESET_VAL(0)) u_hi (
        .CLK(clk), .RST(c_rst), .CE(lo_bo), .LOAD(c_load), .D(hi_d),
        .BO(hi_bo), .ZERO(hi_zero), .UF(hi_uf), .count(hi_cnt)
    );

    typedef struct {
        logic       rst;
        logic       load;
        logic       ce;
        logic [2:0] d;
        logic       chk_bo;
        logic       bo;
        logic [2:0] cnt;
        logic       uf;
    } vec_t;

    typedef struct {
        logic [2:0] cnt;
        logic       uf;
    } exp_t;

    localparam int NVEC = 27;
    vec_t       vecs[NVEC];
    exp_t       sb[$];
    logic [5:0] casc_q[$];
    int         checks = 0;
    int         failures = 0;

    function automatic vec_t mkv(input logic r, input logic l, input logic c, input logic [2:0] dv,
                                 input logic cb, input logic b, input logic [2:0] ec, input logic eu);
        vec_t v;
        v.rst = r; v.load = l; v.ce = c; v.d = dv;
        v.chk_bo = cb; v.bo = b; v.cnt = ec; v.uf = eu;
        return v;
    endfunction

    function automatic void chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Reference step for one stage: wrap target depends on the build.
    function automatic logic [2:0] stage_next(input logic [2:0] c, input logic [2:0] rl, input logic en);
        if (!en) return c;
        if (c != 3'd0) return c - 3'd1;
        return R ? rl : 3'd7;
    endfunction

    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        @(negedge clk);
        rst = v.rst; load = v.load; ce = v.ce; d = v.d;
        #1;
        if (v.chk_bo) chk($sformatf("bo_pre[%0d]", idx), 8'(bo), 8'(v.bo));
        e.cnt = v.cnt; e.uf = v.uf;
        sb.push_back(e);
        @(posedge clk); #1;
        e = sb.pop_front();
        chk($sformatf("count[%0d]", idx), 8'(cnt), 8'(e.cnt));
        chk($sformatf("uf[%0d]", idx), 8'(uf), 8'(e.uf));
        chk($sformatf("zero[%0d]", idx), 8'(zero), 8'(e.cnt == 3'd0));
    endtask

    task automatic casc_run(input logic [2:0] ld_lo, input logic [2:0] ld_hi, input int n);
        logic [2:0] m_lo, m_hi;
        logic       hc;
        logic [5:0] e;
        @(negedge clk);
        c_rst = 1'b0; c_load = 1'b1; c_ce = 1'b0; lo_d = ld_lo; hi_d = ld_hi;
        m_lo = ld_lo; m_hi = ld_hi;
        casc_q.push_back({m_hi, m_lo});
        @(posedge clk); #1;
        e = casc_q.pop_front();
        chk("casc_load", 8'({hi_cnt, lo_cnt}), 8'(e));
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            c_load = 1'b0; c_ce = 1'b1;
            #1;
            hc = (m_lo == 3'd0);
            chk($sformatf("casc_bo[%0d]", i), 8'(lo_bo), 8'(hc));
            m_hi = stage_next(m_hi, ld_hi, hc);
            m_lo = stage_next(m_lo, ld_lo, 1'b1);
            casc_q.push_back({m_hi, m_lo});
            @(posedge clk); #1;
            e = casc_q.pop_front();
            chk($sformatf("casc_val[%0d]", i), 8'({hi_cnt, lo_cnt}), 8'(e));
        end
        @(negedge clk);
        c_ce = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] m;
        logic       muf;
        exp_t       e;

        vecs[0]  = mkv(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd5, 1'b0);
        vecs[1]  = mkv(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 3'd5, 1'b0);
        vecs[2]  = mkv(1'b0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 3'd3, 1'b0);
        vecs[3]  = mkv(1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 3'd2, 1'b0);
        vecs[4]  = mkv(1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 3'd1, 1'b0);
        vecs[5]  = mkv(1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0);
        vecs[6]  = mkv(1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b1, R ? 3'd3 : 3'd7, 1'b1);
        vecs[7]  = mkv(1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, R ? 3'd2 : 3'd6, 1'b1);
        vecs[8]  = mkv(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0);
        vecs[9]  = mkv(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0);
        vecs[10] = mkv(1'b0, 1'b1, 1'b1, 3'd6, 1'b1, 1'b1, 3'd6, 1'b0);
        vecs[11] = mkv(1'b1, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 3'd5, 1'b0);
        vecs[12] = mkv(1'b0, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 3'd2, 1'b0);
        for (int i = 13; i <= 16; i++) begin
            vecs[i] = mkv(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 3'd2, 1'b0);
        end
        vecs[17] = mkv(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0);
        vecs[18] = mkv(1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b1, R ? 3'd0 : 3'd7, 1'b1);
        vecs[19] = mkv(1'b0, 1'b0, 1'b1, 3'd0, 1'b1, R, R ? 3'd0 : 3'd6, 1'b1);
        vecs[20] = mkv(1'b0, 1'b1, 1'b1, 3'd6, 1'b1, R, 3'd6, 1'b0);
        vecs[21] = mkv(1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 3'd5, 1'b0);
        vecs[22] = mkv(1'b0, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 3'd1, 1'b0);
        vecs[23] = mkv(1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0);
        vecs[24] = mkv(1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b1, R ? 3'd1 : 3'd7, 1'b1);
        vecs[25] = mkv(1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, R ? 3'd0 : 3'd6, 1'b1);
        vecs[26] = mkv(1'b0, 1'b0, 1'b1, 3'd0, 1'b1, R, R ? 3'd1 : 3'd5, 1'b1);

        for (int i = 0; i < NVEC; i++) begin
            apply(vecs[i], i);
        end

        casc_run(3'd0, 3'd0, 3);
        casc_run(3'd2, 3'd1, 12);

        // Load 2 then count through the underflow several times.
        @(negedge clk);
        rst = 1'b0; load = 1'b1; ce = 1'b0; d = 3'd2;
        m = 3'd2; muf = 1'b0;
        e.cnt = m; e.uf = muf;
        sb.push_back(e);
        @(posedge clk); #1;
        e = sb.pop_front();
        chk("rl_load", 8'(cnt), 8'(e.cnt));
        chk("rl_load_uf", 8'(uf), 8'(e.uf));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            load = 1'b0; ce = 1'b1;
            if (m == 3'd0) muf = 1'b1;
            m = stage_next(m, 3'd2, 1'b1);
            e.cnt = m; e.uf = muf;
            sb.push_back(e);
            @(posedge clk); #1;
            e = sb.pop_front();
            chk($sformatf("rl_count[%0d]", i), 8'(cnt), 8'(e.cnt));
            chk($sformatf("rl_uf[%0d]", i), 8'(uf), 8'(e.uf));
        end
        @(negedge clk);
        ce = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
